// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Instruction-fetch sequencer. Owns the program counter, runs a
//             req/ack handshake with instruction memory, registers each
//             returned word and hands it (with its PC) to the decoder over a
//             valid/ready handshake. Handles redirects, halting and a count
//             of accepted instructions.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             imem_req/addr/ack/rdata - instruction memory handshake
//             inst_o, pc_o            - registered instruction and its PC
//             inst_valid, inst_ready  - decoder handshake
//             redirect, redirect_pc   - one-cycle PC replacement
//             halt, halted            - halt request / halted status
//             fetch_cnt               - accepted-instruction count (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    localparam logic [1:0]  c_ST_BOOT   = 2'd0;
    localparam logic [1:0]  c_ST_FETCH  = 2'd1;
    localparam logic [1:0]  c_ST_HOLD   = 2'd2;
    localparam logic [1:0]  c_ST_HALTED = 2'd3;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;     // address of the request currently on the bus
    logic        r_discard;  // outstanding request was superseded by a redirect
    logic [31:0] r_inst;
    logic [31:0] r_pc_o;
    logic [31:0] r_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_discard_nxt;
    logic        w_capture;
    logic        w_accept;
    logic [31:0] w_redir_pc;
    logic        w_unused;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_discard_nxt = r_discard;
        w_capture     = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            c_ST_BOOT: begin
                if (redirect) w_pc_nxt = w_redir_pc;
                w_state_nxt = halt ? c_ST_HALTED : c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (redirect) w_pc_nxt = w_redir_pc;
                if (imem_ack) begin
                    // The single outstanding request completes here, so the
                    // discard flag is always consumed. Data is kept only if
                    // neither an earlier nor a same-cycle redirect killed it.
                    w_discard_nxt = 1'b0;
                    if (!r_discard && !redirect) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_ST_HOLD;
                    end
                end else if (redirect) begin
                    w_discard_nxt = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (redirect) begin
                    // Redirect cancels the held instruction even if accepted.
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = halt ? c_ST_HALTED : c_ST_FETCH;
                end else if (inst_ready) begin
                    w_accept    = 1'b1;
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = halt ? c_ST_HALTED : c_ST_FETCH;
                end
            end
            c_ST_HALTED: begin
                if (redirect) w_pc_nxt = w_redir_pc;
                if (!halt) w_state_nxt = c_ST_FETCH;
            end
            default: begin
                w_state_nxt = c_ST_BOOT;
            end
        endcase
        // Bus address is frozen while a request waits for its ack; otherwise
        // it tracks the next PC so a new request starts at the right place.
        w_addr_nxt = ((r_state == c_ST_FETCH) && !imem_ack) ? r_addr : w_pc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_BOOT;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_discard <= 1'b0;
            r_inst    <= c_NOP;
            r_pc_o    <= RESET_PC;
            r_cnt     <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_addr    <= w_addr_nxt;
            r_discard <= w_discard_nxt;
            if (w_capture) begin
                r_inst <= imem_rdata;
                r_pc_o <= r_pc;
            end
            if (w_accept) r_cnt <= r_cnt + 32'd1;
        end
    end

    assign imem_req   = (r_state == c_ST_FETCH);
    assign imem_addr  = r_addr;
    assign inst_valid = (r_state == c_ST_HOLD);
    assign halted     = (r_state == c_ST_HALTED);
    assign inst_o     = r_inst;
    assign pc_o       = r_pc_o;
    assign fetch_cnt  = r_cnt;

endmodule
`default_nettype wire
